// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences ALU, register file, PC and the unified
// memory port over several cycles per instruction; aluop is decoded downstream.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               adrsrc,
  output logic               memwrite,
  output logic               irwrite,
  output logic [1:0]         resultsrc,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               regwrite,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  assign state_o = STATE_W'(state);

  always_comb begin
    state_next    = FETCH;
    pcwrite       = 1'b0;
    adrsrc        = 1'b0;
    memwrite      = 1'b0;
    irwrite       = 1'b0;
    resultsrc     = 2'b00;
    alusrca       = 2'b00;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    regwrite      = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU computes oldPC + imm here so BEQ can reuse it as the branch target
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            illegal_instr = 1'b1;
            state_next    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alusrca    = 2'b10;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alusrca    = 2'b10;
        aluop      = 2'b01;
        pcwrite    = zero;
        instr_done = 1'b1;
      end
      JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcwrite    = 1'b1;
        state_next = ALUWB;
      end
      default: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
    endcase
    // Reset forces FETCH asynchronously; also mask mem_ready-driven enables
    if (rst) begin
      pcwrite       = 1'b0;
      irwrite       = 1'b0;
      memwrite      = 1'b0;
      regwrite      = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares state and the packed control word to hand-derived values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, instr_done, illegal_instr;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .regwrite(regwrite), .instr_done(instr_done), .illegal_instr(illegal_instr),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {pcwrite,adrsrc,memwrite,irwrite,resultsrc,alusrca,alusrcb,aluop,regwrite,instr_done,illegal_instr}
  logic [14:0] ctl;
  assign ctl = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
                aluop, regwrite, instr_done, illegal_instr};

  localparam logic [14:0] C_FETCH1 = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_FETCH0 = {1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_DECILL = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0,1'b1};
  localparam logic [14:0] C_MEMADR = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_MEMRD  = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_MEMWB  = {1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,1'b1,1'b1,1'b0};
  localparam logic [14:0] C_MW0    = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_MW1    = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0};
  localparam logic [14:0] C_EXECR  = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_EXECI  = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0,1'b0,1'b0};
  localparam logic [14:0] C_ALUWB  = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,1'b1,1'b0};
  localparam logic [14:0] C_BEQ1   = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b1,1'b0};
  localparam logic [14:0] C_BEQ0   = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b1,1'b0};
  localparam logic [14:0] C_JAL    = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check mid-cycle, advance to just after the next edge
  task automatic cyc(input string tag, input logic mr, input logic z,
                     input logic [3:0] exp_state, input logic [14:0] exp_ctl);
    mem_ready = mr;
    zero      = z;
    #3;
    check_eq({tag, "_state"}, 32'(state_o), 32'(exp_state));
    check_eq({tag, "_ctl"},   32'(ctl),     32'(exp_ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 7'b0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_ctl",   32'(ctl),     32'(C_FETCH0));
    @(posedge clk); #1;
    rst = 1'b0;

    // lw, no stalls: 0,1,2,3,4
    op = 7'b0000011;
    cyc("lw_f",  1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("lw_d",  1'b1, 1'b0, 4'd1, C_DEC);
    cyc("lw_ma", 1'b1, 1'b0, 4'd2, C_MEMADR);
    cyc("lw_mr", 1'b1, 1'b0, 4'd3, C_MEMRD);
    cyc("lw_wb", 1'b1, 1'b0, 4'd4, C_MEMWB);

    // lw with one fetch stall and one read stall
    cyc("lws_f0",  1'b0, 1'b0, 4'd0, C_FETCH0);
    cyc("lws_f1",  1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("lws_d",   1'b1, 1'b0, 4'd1, C_DEC);
    cyc("lws_ma",  1'b1, 1'b0, 4'd2, C_MEMADR);
    cyc("lws_mr0", 1'b0, 1'b0, 4'd3, C_MEMRD);
    cyc("lws_mr1", 1'b1, 1'b0, 4'd3, C_MEMRD);
    cyc("lws_wb",  1'b1, 1'b0, 4'd4, C_MEMWB);

    // sw with three stall cycles in MEMWRITE
    op = 7'b0100011;
    cyc("sw_f",   1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("sw_d",   1'b1, 1'b0, 4'd1, C_DEC);
    cyc("sw_ma",  1'b1, 1'b0, 4'd2, C_MEMADR);
    for (int i = 0; i < 3; i++) cyc("sw_mw0", 1'b0, 1'b0, 4'd5, C_MW0);
    cyc("sw_mw1", 1'b1, 1'b0, 4'd5, C_MW1);

    // R-type and I-type
    op = 7'b0110011;
    cyc("r_f",  1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("r_d",  1'b1, 1'b0, 4'd1, C_DEC);
    cyc("r_ex", 1'b1, 1'b0, 4'd6, C_EXECR);
    cyc("r_wb", 1'b1, 1'b0, 4'd8, C_ALUWB);
    op = 7'b0010011;
    cyc("i_f",  1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("i_d",  1'b1, 1'b0, 4'd1, C_DEC);
    cyc("i_ex", 1'b1, 1'b0, 4'd7, C_EXECI);
    cyc("i_wb", 1'b1, 1'b0, 4'd8, C_ALUWB);

    // beq taken and not taken
    op = 7'b1100011;
    cyc("beqt_f", 1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("beqt_d", 1'b1, 1'b0, 4'd1, C_DEC);
    cyc("beqt_b", 1'b1, 1'b1, 4'd9, C_BEQ1);
    cyc("beqn_f", 1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("beqn_d", 1'b1, 1'b0, 4'd1, C_DEC);
    cyc("beqn_b", 1'b1, 1'b0, 4'd9, C_BEQ0);

    // jal
    op = 7'b1101111;
    cyc("jal_f",  1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("jal_d",  1'b1, 1'b0, 4'd1, C_DEC);
    cyc("jal_j",  1'b1, 1'b0, 4'd10, C_JAL);
    cyc("jal_wb", 1'b1, 1'b0, 4'd8, C_ALUWB);

    // illegal opcodes
    op = 7'b1111111;
    cyc("ill_f", 1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("ill_d", 1'b1, 1'b0, 4'd1, C_DECILL);
    op = 7'b0000000;
    cyc("ill2_f", 1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("ill2_d", 1'b1, 1'b0, 4'd1, C_DECILL);

    // reset asserted mid-EXECR
    op = 7'b0110011;
    cyc("rr_f", 1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("rr_d", 1'b1, 1'b0, 4'd1, C_DEC);
    mem_ready = 1'b1;
    #2;
    check_eq("rr_ex_state", 32'(state_o), 32'd6);
    rst = 1'b1;
    #1;
    check_eq("rr_async_state", 32'(state_o), 32'd0);
    check_eq("rr_async_ctl",   32'(ctl),     32'(C_FETCH0));
    @(posedge clk); #1;
    check_eq("rr_hold_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    cyc("rr_post_f", 1'b1, 1'b0, 4'd0, C_FETCH1);
    cyc("rr_post_d", 1'b1, 1'b0, 4'd1, C_DEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
